// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between two writeback
// requesters; each write is sequenced setup -> one-cycle pulse -> hold.
// Optional zeroing sweep of registers 1..N-1 is built when REGFILE_ARB_CLEAR_EN is defined.
module regfile_write_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int SETUP_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] rf_reg_wr,
  output logic [DATA_W-1:0] rf_data,
  output logic              rf_wr_enable,
  output logic              busy
`ifdef REGFILE_ARB_CLEAR_EN
  ,
  input  logic              clear_req,
  output logic              clear_done
`endif
);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_e;

  localparam int CNT_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_en_q, wr_en_d;
  logic              last_grant_q, last_grant_d;
  logic              grant0, grant1;
  logic              xfer0, xfer1;
  logic              clear_block;

`ifdef REGFILE_ARB_CLEAR_EN
  logic pend_q, pend_d;
  logic sweep_q, sweep_d;
  logic done_q, done_d;

  assign clear_block = pend_q;
  assign clear_done  = done_q;
`else
  assign clear_block = 1'b0;
`endif

  // On a tie the requester that did not win last time is granted.
  assign grant0 = req0_valid && (!req1_valid || last_grant_q);
  assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

  assign req0_ready = (state_q == IDLE) && grant0 && !clear_block;
  assign req1_ready = (state_q == IDLE) && grant1 && !clear_block;
  assign xfer0      = req0_valid && req0_ready;
  assign xfer1      = req1_valid && req1_ready;

  assign rf_reg_wr    = addr_q;
  assign rf_data      = data_q;
  assign rf_wr_enable = wr_en_q;
  assign busy         = (state_q != IDLE);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    data_d       = data_q;
    wr_en_d      = 1'b0;
    last_grant_d = last_grant_q;
`ifdef REGFILE_ARB_CLEAR_EN
    pend_d  = pend_q | (clear_req & ~sweep_q);
    sweep_d = sweep_q;
    done_d  = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
`ifdef REGFILE_ARB_CLEAR_EN
        if (pend_q) begin
          pend_d  = 1'b0;
          sweep_d = 1'b1;
          addr_d  = ADDR_W'(1);
          data_d  = '0;
          cnt_d   = '0;
          state_d = SETUP;
        end else
`endif
        if (xfer0 || xfer1) begin
          addr_d       = xfer0 ? req0_addr : req1_addr;
          data_d       = xfer0 ? req0_data : req1_data;
          last_grant_d = xfer1;
          cnt_d        = '0;
          // Register 0 is hardwired; skip straight to HOLD without a pulse.
          state_d      = (addr_d == '0) ? HOLD : SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
          state_d = PULSE;
          wr_en_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PULSE: state_d = HOLD;
      HOLD: begin
        state_d = IDLE;
`ifdef REGFILE_ARB_CLEAR_EN
        if (sweep_q) begin
          if (addr_q == '1) begin
            sweep_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            addr_d  = addr_q + 1'b1;
            cnt_d   = '0;
            state_d = SETUP;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      wr_en_q      <= 1'b0;
      last_grant_q <= 1'b1;
`ifdef REGFILE_ARB_CLEAR_EN
      pend_q       <= 1'b0;
      sweep_q      <= 1'b0;
      done_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      wr_en_q      <= wr_en_d;
      last_grant_q <= last_grant_d;
`ifdef REGFILE_ARB_CLEAR_EN
      pend_q       <= pend_d;
      sweep_q      <= sweep_d;
      done_q       <= done_d;
`endif
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (SETUP_CYC = 1).
// The clear-sweep scenario is compiled only when REGFILE_ARB_CLEAR_EN is defined.
module tb_regfile_write_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0_valid, req1_valid;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              req0_ready, req1_ready;
  logic [ADDR_W-1:0] rf_reg_wr;
  logic [DATA_W-1:0] rf_data;
  logic              rf_wr_enable;
  logic              busy;
`ifdef REGFILE_ARB_CLEAR_EN
  logic              clear_req;
  logic              clear_done;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SETUP_CYC(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_addr    (req0_addr),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_addr    (req1_addr),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .rf_reg_wr    (rf_reg_wr),
    .rf_data      (rf_data),
    .rf_wr_enable (rf_wr_enable),
    .busy         (busy)
`ifdef REGFILE_ARB_CLEAR_EN
    ,
    .clear_req    (clear_req),
    .clear_done   (clear_done)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the IDLE cycle where the transfer is accepted; walks SETUP, PULSE, HOLD, IDLE.
  task automatic run_write(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input bit drop0, input bit drop1);
    tick();
    if (drop0) req0_valid = 1'b0;
    if (drop1) req1_valid = 1'b0;
    check({tag, " setup busy"}, 32'(busy), 32'd1);
    check({tag, " setup en"},   32'(rf_wr_enable), 32'd0);
    check({tag, " setup addr"}, 32'(rf_reg_wr), 32'(a));
    check({tag, " setup data"}, rf_data, d);
    tick();
    check({tag, " pulse en"},   32'(rf_wr_enable), 32'd1);
    check({tag, " pulse addr"}, 32'(rf_reg_wr), 32'(a));
    check({tag, " pulse data"}, rf_data, d);
    tick();
    check({tag, " hold en"},    32'(rf_wr_enable), 32'd0);
    check({tag, " hold busy"},  32'(busy), 32'd1);
    check({tag, " hold addr"},  32'(rf_reg_wr), 32'(a));
    tick();
    check({tag, " idle busy"},  32'(busy), 32'd0);
    check({tag, " idle en"},    32'(rf_wr_enable), 32'd0);
    check({tag, " idle addr"},  32'(rf_reg_wr), 32'(a));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
`ifdef REGFILE_ARB_CLEAR_EN
    clear_req = 1'b0;
`endif
    tick();
    tick();
    check("reset addr",   32'(rf_reg_wr), 32'd0);
    check("reset data",   rf_data, 32'd0);
    check("reset en",     32'(rf_wr_enable), 32'd0);
    check("reset busy",   32'(busy), 32'd0);
    check("reset ready0", 32'(req0_ready), 32'd0);
    check("reset ready1", 32'(req1_ready), 32'd0);
    rst_n = 1'b1;

    // Both pending from reset: req0 first, then strict alternation.
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h0A0A_0A0A;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h0B0B_0B0B;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("alt ready0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("alt ready1", 32'(req1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i % 2 == 0) run_write("alt0", 5'd3, 32'h0A0A_0A0A, i == 5, i == 5);
      else            run_write("alt1", 5'd4, 32'h0B0B_0B0B, i == 5, i == 5);
    end
    #1;
    check("alt drained", 32'(busy), 32'd0);

    // Single requester, latency and data path.
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEAD_BEEF;
    #1;
    check("t1 ready0", 32'(req0_ready), 32'd1);
    check("t1 ready1", 32'(req1_ready), 32'd0);
    run_write("t1", 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0);

    // Write to register 0: accepted, no pulse, idle two cycles later.
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFFFF_FFFF;
    #1;
    check("t3 ready1", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    check("t3 c1 en",   32'(rf_wr_enable), 32'd0);
    check("t3 c1 busy", 32'(busy), 32'd1);
    check("t3 c1 addr", 32'(rf_reg_wr), 32'd0);
    check("t3 c1 data", rf_data, 32'hFFFF_FFFF);
    tick();
    check("t3 c2 en",   32'(rf_wr_enable), 32'd0);
    check("t3 c2 busy", 32'(busy), 32'd0);

    // Reset asserted during PULSE.
    req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 32'h0000_1234;
    #1;
    check("t4 ready0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    tick();
    check("t4 pulse en", 32'(rf_wr_enable), 32'd1);
    rst_n = 1'b0;
    tick();
    check("t4 rst en",   32'(rf_wr_enable), 32'd0);
    check("t4 rst busy", 32'(busy), 32'd0);
    check("t4 rst addr", 32'(rf_reg_wr), 32'd0);
    check("t4 rst data", rf_data, 32'd0);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h0000_0077;
    #1;
    check("t4 ready0 after", 32'(req0_ready), 32'd1);
    run_write("t4", 5'd7, 32'h0000_0077, 1'b1, 1'b0);

`ifdef REGFILE_ARB_CLEAR_EN
    // Clear requested while req0 is in SETUP; req1 waits for the sweep.
    req0_valid = 1'b1; req0_addr = 5'd2; req0_data = 32'h0000_0022;
    #1;
    check("t5 ready0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    clear_req  = 1'b1;
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h0000_0066;
    tick();
    clear_req = 1'b0;
    check("t5 req0 pulse en",   32'(rf_wr_enable), 32'd1);
    check("t5 req0 pulse addr", 32'(rf_reg_wr), 32'd2);
    tick();
    tick();
    check("t5 idle busy",   32'(busy), 32'd0);
    check("t5 idle ready1", 32'(req1_ready), 32'd0);
    for (int a = 1; a < 32; a++) begin
      tick();
      check("t5 sw setup addr", 32'(rf_reg_wr), 32'(a));
      check("t5 sw setup data", rf_data, 32'd0);
      check("t5 sw ready1",     32'(req1_ready), 32'd0);
      check("t5 sw done",       32'(clear_done), 32'd0);
      tick();
      check("t5 sw pulse en",   32'(rf_wr_enable), 32'd1);
      check("t5 sw pulse addr", 32'(rf_reg_wr), 32'(a));
      tick();
      check("t5 sw hold en",    32'(rf_wr_enable), 32'd0);
    end
    tick();
    check("t5 done",        32'(clear_done), 32'd1);
    check("t5 done busy",   32'(busy), 32'd0);
    check("t5 ready1 next", 32'(req1_ready), 32'd1);
    run_write("t5 req1", 5'd6, 32'h0000_0066, 1'b0, 1'b1);
    check("t5 done cleared", 32'(clear_done), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
